rtc_bus_arbiter: RTL and testbench

Arbitrates the single RTC bus protocol engine among the system's transaction sources: initialisation, reset, user write, chronometer programming and permanent read. The winner is chosen by fixed priority, with a starvation guard on the lowest-priority source. The block issues one transaction at a time to the protocol engine, returns read data and acknowledges to the winner, then enforces a bus recovery gap. It sits between the control state machines and the RTC protocol engine, replacing the ad-hoc address/data muxing in the top level.

---
 rtl/rtc_bus_arbiter_if.sv | 33 +++
 rtl/rtc_bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_arbiter_if.sv
// Signal bundle between the transaction sources, the RTC bus arbiter and the RTC protocol engine.
interface rtc_bus_arbiter_if #(
    parameter int N_REQ = 5
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   wr;
    logic [8*N_REQ-1:0] addr;
    logic [8*N_REQ-1:0] wdata;
    logic [N_REQ-1:0]   lock;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   ack;
    logic [7:0]         rdata;
    logic               err;
    logic               busy;
    logic               proto_start;
    logic               proto_wr;
    logic [7:0]         proto_addr;
    logic [7:0]         proto_wdata;
    logic               proto_done;
    logic [7:0]         proto_rdata;

    // Arbiter side
    modport slave (
        input  req, wr, addr, wdata, lock, proto_done, proto_rdata,
        output gnt, ack, rdata, err, busy, proto_start, proto_wr, proto_addr, proto_wdata
    );

    // Requesters plus protocol engine side
    modport master (
        output req, wr, addr, wdata, lock, proto_done, proto_rdata,
        input  gnt, ack, rdata, err, busy, proto_start, proto_wr, proto_addr, proto_wdata
    );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Fixed-priority arbiter for the single RTC protocol engine, with a starvation guard on the
// lowest-priority source, transaction timeout, locked bursts and an enforced bus recovery gap.
module rtc_bus_arbiter #(
    parameter int N_REQ      = 5,
    parameter int GAP_CYC    = 4,
    parameter int TIMEOUT    = 255,
    parameter int STARVE_LIM = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    rtc_bus_arbiter_if.slave bus
);
    localparam int               IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);
    localparam logic [7:0]       TIMEOUT_V  = 8'(TIMEOUT);
    localparam logic [7:0]       GAP_LAST   = 8'(GAP_CYC - 1);
    localparam logic [7:0]       STARVE_MAX = 8'(STARVE_LIM);
    localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic               pwr_q, pwr_d;
    logic [7:0]         paddr_q, paddr_d;
    logic [7:0]         pwdata_q, pwdata_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [7:0]         timer_q, timer_d;
    logic [7:0]         gap_q, gap_d;
    logic               eflag_q, eflag_d;
    logic [7:0]         starve_q, starve_d;

    logic               grant_s;
    logic [IDX_W-1:0]   win_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               sel_wr_s;
    logic [7:0]         sel_addr_s;
    logic [7:0]         sel_wdata_s;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REQ-1:0] r);
        lowest_set = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    // Winner: lowest index, unless the last requester has waited through STARVE_LIM grants
    always_comb begin
        if ((starve_q == STARVE_MAX) && bus.req[LAST_IDX]) begin
            win_s = LAST_IDX;
        end else begin
            win_s = lowest_set(bus.req);
        end
    end

    // A locked relatch keeps the current owner; otherwise the arbitration winner is latched
    assign grant_idx_s = (state_q == ST_GAP) ? idx_q : win_s;

    // AND-OR mux of the grantee's direction, address and write data
    always_comb begin
        sel_wr_s    = 1'b0;
        sel_addr_s  = 8'h00;
        sel_wdata_s = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            sel_wr_s    = sel_wr_s | ((grant_idx_s == IDX_W'(i)) & bus.wr[i]);
            sel_addr_s  = sel_addr_s | ({8{grant_idx_s == IDX_W'(i)}} & bus.addr[8*i +: 8]);
            sel_wdata_s = sel_wdata_s | ({8{grant_idx_s == IDX_W'(i)}} & bus.wdata[8*i +: 8]);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rdata_d = rdata_q;
        timer_d = timer_q;
        gap_d   = gap_q;
        eflag_d = eflag_q;
        grant_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant_s = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                timer_d = 8'd0;
                eflag_d = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the timeout cycle wins over the timeout
                if (bus.proto_done) begin
                    rdata_d = pwr_q ? rdata_q : bus.proto_rdata;
                    state_d = ST_ACK;
                end else if (timer_q == TIMEOUT_V) begin
                    eflag_d = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_ACK: begin
                gnt_d   = '0;
                gap_d   = 8'd0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (bus.lock[idx_q] && bus.req[idx_q]) begin
                        grant_s = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        idx_d    = grant_s ? grant_idx_s : idx_q;
        gnt_d    = grant_s ? (ONE_HOT0 << grant_idx_s) : gnt_d;
        pwr_d    = grant_s ? sel_wr_s : pwr_q;
        paddr_d  = grant_s ? sel_addr_s : paddr_q;
        pwdata_d = grant_s ? sel_wdata_s : pwdata_q;

        if (!bus.req[LAST_IDX]) begin
            starve_d = 8'd0;
        end else if (grant_s && (grant_idx_s == LAST_IDX)) begin
            starve_d = 8'd0;
        end else if (grant_s && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 8'd1;
        end else begin
            starve_d = starve_q;
        end

        start_d = (state_d == ST_ISSUE);
        busy_d  = (state_d != ST_IDLE);
        ack_d   = (state_d == ST_ACK) ? gnt_q : '0;
        err_d   = (state_d == ST_ACK) && eflag_d;
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            pwr_q    <= 1'b0;
            paddr_q  <= 8'h00;
            pwdata_q <= 8'h00;
            rdata_q  <= 8'h00;
            timer_q  <= 8'd0;
            gap_q    <= 8'd0;
            eflag_q  <= 1'b0;
            starve_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            pwr_q    <= pwr_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
            eflag_q  <= eflag_d;
            starve_q <= starve_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.ack         = ack_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
    assign bus.rdata       = rdata_q;
    assign bus.proto_start = start_q;
    assign bus.proto_wr    = pwr_q;
    assign bus.proto_addr  = paddr_q;
    assign bus.proto_wdata = pwdata_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_rtc_bus_arbiter;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    rtc_bus_arbiter_if #(.N_REQ(N)) bus ();

    rtc_bus_arbiter #(
        .N_REQ(N), .GAP_CYC(4), .TIMEOUT(255), .STARVE_LIM(8)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // From the negedge where the start pulse is visible: complete in the first WAIT cycle,
    // returning at the negedge where ack is visible.
    task automatic complete(input logic [7:0] rd);
        @(negedge clk);
        bus.proto_done  = 1'b1;
        bus.proto_rdata = rd;
        @(negedge clk);
        bus.proto_done  = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        chk_cnt++; if ({bus.gnt, bus.ack, bus.err, bus.busy, bus.proto_start, bus.proto_wr, bus.proto_addr, bus.proto_wdata, bus.rdata} !== 38'd0) $display("FAIL reset_outputs got=%h exp=0", {bus.gnt, bus.ack, bus.err, bus.busy, bus.proto_start, bus.proto_wr, bus.proto_addr, bus.proto_wdata, bus.rdata}); else pass_cnt++;
        rst_n = 1'b1;
        step(3);
        chk_cnt++; if ({bus.busy, bus.ack} !== 6'd0) $display("FAIL reset_idle got=%b exp=0", {bus.busy, bus.ack}); else pass_cnt++;
    endtask

    task automatic test_single_read();
        bus.wr[4] = 1'b0; bus.addr[32 +: 8] = 8'h21; bus.req[4] = 1'b1;
        step(1);
        chk_cnt++; if (bus.proto_start !== 1'b1) $display("FAIL rd_start got=%b exp=1", bus.proto_start); else pass_cnt++;
        chk_cnt++; if ({bus.proto_wr, bus.proto_addr} !== 9'h021) $display("FAIL rd_wr_addr got=%h exp=021", {bus.proto_wr, bus.proto_addr}); else pass_cnt++;
        chk_cnt++; if (bus.gnt !== 5'b10000) $display("FAIL rd_gnt got=%b exp=10000", bus.gnt); else pass_cnt++;
        step(1);
        chk_cnt++; if (bus.proto_start !== 1'b0) $display("FAIL rd_start_pulse got=%b exp=0", bus.proto_start); else pass_cnt++;
        step(8);
        bus.proto_done = 1'b1; bus.proto_rdata = 8'h59;
        step(1);
        bus.proto_done = 1'b0;
        chk_cnt++; if ({bus.ack, bus.err, bus.rdata} !== {5'b10000, 1'b0, 8'h59}) $display("FAIL rd_ack got=%b/%b/%h exp=10000/0/59", bus.ack, bus.err, bus.rdata); else pass_cnt++;
        bus.req[4] = 1'b0;
        step(1);
        chk_cnt++; if (bus.ack !== 5'b00000) $display("FAIL rd_ack_pulse got=%b exp=00000", bus.ack); else pass_cnt++;
        bus.proto_done = 1'b1;
        step(1);
        bus.proto_done = 1'b0;
        chk_cnt++; if ({bus.ack, bus.proto_start} !== 6'd0) $display("FAIL rd_stray_done got=%b exp=0", {bus.ack, bus.proto_start}); else pass_cnt++;
        step(2);
        chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL rd_gap_busy got=%b exp=1", bus.busy); else pass_cnt++;
        step(1);
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL rd_gap_end got=%b exp=0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_priority();
        bus.wr[2] = 1'b0; bus.wr[4] = 1'b0;
        bus.addr[16 +: 8] = 8'h33; bus.addr[32 +: 8] = 8'h44;
        bus.req[2] = 1'b1; bus.req[4] = 1'b1;
        step(1);
        chk_cnt++; if ({bus.gnt, bus.proto_addr} !== {5'b00100, 8'h33}) $display("FAIL prio_first got=%b/%h exp=00100/33", bus.gnt, bus.proto_addr); else pass_cnt++;
        complete(8'h77);
        chk_cnt++; if ({bus.ack, bus.rdata} !== {5'b00100, 8'h77}) $display("FAIL prio_ack1 got=%b/%h exp=00100/77", bus.ack, bus.rdata); else pass_cnt++;
        bus.req[2] = 1'b0;
        step(5);
        chk_cnt++; if ({bus.gnt, bus.busy} !== 6'd0) $display("FAIL prio_idle got=%b exp=0", {bus.gnt, bus.busy}); else pass_cnt++;
        step(1);
        chk_cnt++; if ({bus.gnt, bus.proto_start, bus.proto_addr} !== {5'b10000, 1'b1, 8'h44}) $display("FAIL prio_second got=%b/%b/%h exp=10000/1/44", bus.gnt, bus.proto_start, bus.proto_addr); else pass_cnt++;
        complete(8'h88);
        chk_cnt++; if ({bus.ack, bus.rdata} !== {5'b10000, 8'h88}) $display("FAIL prio_ack2 got=%b/%h exp=10000/88", bus.ack, bus.rdata); else pass_cnt++;
        bus.req[4] = 1'b0;
        step(5);
    endtask

    task automatic test_lock_burst();
        logic [7:0] la [3] = '{8'h02, 8'h03, 8'h04};
        logic [7:0] ld [3] = '{8'h10, 8'h20, 8'h30};
        bus.wr[0] = 1'b1; bus.lock[0] = 1'b1; bus.addr[0 +: 8] = la[0]; bus.wdata[0 +: 8] = ld[0];
        bus.wr[1] = 1'b0; bus.addr[8 +: 8] = 8'h55;
        bus.req[0] = 1'b1; bus.req[1] = 1'b1;
        step(1);
        for (int k = 0; k < 3; k++) begin
            chk_cnt++; if ({bus.gnt, bus.proto_start, bus.proto_wr, bus.proto_addr, bus.proto_wdata} !== {5'b00001, 1'b1, 1'b1, la[k], ld[k]}) $display("FAIL lock_issue%0d got=%b/%b/%b/%h/%h exp=00001/1/1/%h/%h", k, bus.gnt, bus.proto_start, bus.proto_wr, bus.proto_addr, bus.proto_wdata, la[k], ld[k]); else pass_cnt++;
            complete(8'hEE);
            chk_cnt++; if ({bus.ack, bus.rdata} !== {5'b00001, 8'h88}) $display("FAIL lock_ack%0d got=%b/%h exp=00001/88", k, bus.ack, bus.rdata); else pass_cnt++;
            if (k < 2) begin
                bus.addr[0 +: 8] = la[k+1]; bus.wdata[0 +: 8] = ld[k+1];
                step(5);
            end else begin
                bus.req[0] = 1'b0; bus.lock[0] = 1'b0;
            end
        end
        step(6);
        chk_cnt++; if ({bus.gnt, bus.proto_addr} !== {5'b00010, 8'h55}) $display("FAIL lock_next got=%b/%h exp=00010/55", bus.gnt, bus.proto_addr); else pass_cnt++;
        complete(8'h66);
        chk_cnt++; if ({bus.ack, bus.rdata} !== {5'b00010, 8'h66}) $display("FAIL lock_next_ack got=%b/%h exp=00010/66", bus.ack, bus.rdata); else pass_cnt++;
        bus.req[1] = 1'b0;
        step(5);
    endtask

    task automatic test_timeout();
        logic early = 1'b0;
        bus.wr[3] = 1'b0; bus.addr[24 +: 8] = 8'h3C; bus.req[3] = 1'b1;
        step(1);
        chk_cnt++; if ({bus.gnt, bus.proto_start, bus.proto_addr} !== {5'b01000, 1'b1, 8'h3C}) $display("FAIL to_issue got=%b/%b/%h exp=01000/1/3c", bus.gnt, bus.proto_start, bus.proto_addr); else pass_cnt++;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            if ((bus.ack !== 5'd0) || (bus.err !== 1'b0)) early = 1'b1;
        end
        chk_cnt++; if (early !== 1'b0) $display("FAIL to_early_ack got=%b exp=0", early); else pass_cnt++;
        step(1);
        chk_cnt++; if ({bus.ack, bus.err, bus.rdata} !== {5'b01000, 1'b1, 8'h66}) $display("FAIL to_ack_err got=%b/%b/%h exp=01000/1/66", bus.ack, bus.err, bus.rdata); else pass_cnt++;
        bus.req[3] = 1'b0;
        step(1);
        chk_cnt++; if ({bus.ack, bus.err} !== 6'd0) $display("FAIL to_err_pulse got=%b exp=0", {bus.ack, bus.err}); else pass_cnt++;
        step(4);
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL to_busy_end got=%b exp=0", bus.busy); else pass_cnt++;
        bus.addr[24 +: 8] = 8'h3D; bus.req[3] = 1'b1;
        step(1);
        step(256);
        chk_cnt++; if (bus.ack !== 5'd0) $display("FAIL to_edge_pre got=%b exp=00000", bus.ack); else pass_cnt++;
        bus.proto_done = 1'b1; bus.proto_rdata = 8'h9A;
        step(1);
        bus.proto_done = 1'b0;
        chk_cnt++; if ({bus.ack, bus.err, bus.rdata} !== {5'b01000, 1'b0, 8'h9A}) $display("FAIL to_edge_done got=%b/%b/%h exp=01000/0/9a", bus.ack, bus.err, bus.rdata); else pass_cnt++;
        bus.req[3] = 1'b0;
        step(5);
    endtask

    task automatic test_starvation();
        logic [4:0] exp_gnt;
        bus.wr[1] = 1'b0; bus.addr[8 +: 8] = 8'h11;
        bus.wr[4] = 1'b0; bus.addr[32 +: 8] = 8'h44;
        bus.req[1] = 1'b1; bus.req[4] = 1'b1;
        step(1);
        for (int g = 0; g < 9; g++) begin
            exp_gnt = (g < 8) ? 5'b00010 : 5'b10000;
            chk_cnt++; if (bus.gnt !== exp_gnt) $display("FAIL starve_gnt%0d got=%b exp=%b", g, bus.gnt, exp_gnt); else pass_cnt++;
            if (g == 8) begin
                chk_cnt++; if (dut.starve_q !== 8'd0) $display("FAIL starve_clear got=%0d exp=0", dut.starve_q); else pass_cnt++;
            end
            complete(8'(g));
            if (g < 8) step(6);
        end
        bus.req[1] = 1'b0; bus.req[4] = 1'b0;
        step(5);
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL starve_end got=%b exp=0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic stray = 1'b0;
        bus.wr[0] = 1'b0; bus.lock[0] = 1'b0; bus.addr[0 +: 8] = 8'h0A; bus.req[0] = 1'b1;
        step(3);
        chk_cnt++; if ({bus.busy, bus.gnt} !== 6'b1_00001) $display("FAIL ar_pre got=%b exp=100001", {bus.busy, bus.gnt}); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if ({bus.gnt, bus.ack, bus.err, bus.busy, bus.proto_start, bus.proto_wr, bus.proto_addr, bus.proto_wdata, bus.rdata} !== 38'd0) $display("FAIL ar_outputs got=%h exp=0", {bus.gnt, bus.ack, bus.err, bus.busy, bus.proto_start, bus.proto_wr, bus.proto_addr, bus.proto_wdata, bus.rdata}); else pass_cnt++;
        bus.req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.proto_done = 1'b1;
        @(negedge clk);
        bus.proto_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if ((bus.ack !== 5'd0) || (bus.err !== 1'b0) || (bus.busy !== 1'b0) || (bus.proto_start !== 1'b0)) stray = 1'b1;
            @(negedge clk);
        end
        chk_cnt++; if (stray !== 1'b0) $display("FAIL ar_stray got=%b exp=0", stray); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b1;
        bus.req = '0; bus.wr = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
        bus.proto_done = 1'b0; bus.proto_rdata = 8'h00;
        #1 rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_priority();
        test_lock_burst();
        test_timeout();
        test_starvation();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
